// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the bit-counter width rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-bit operand still needs a one-bit counter, so clamp at 1.
  function automatic int CNT_W(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the arithmetic slice of the bit-serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice, LSB first, start/ready/done.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = CNT_W(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Written as shifts so the WIDTH=1 case needs no special slicing.
  assign r_next   = (r_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          r_sh_d  = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = r_next;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = r_next;
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB during the last slice.
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == ADD) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vectors, start-ignore, mid-op reset,
// and an exhaustive WIDTH=4 instance.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       cinIn;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] opA4;
  logic [3:0] opB4;
  logic       cinIn4;
  logic       ready4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
  logic       ovf4;
`endif

  int testCount;
  int failCount;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (opA),
    .op_b  (opB),
    .cin   (cinIn),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .op_a  (opA4),
    .op_b  (opB4),
    .cin   (cinIn4),
    .ready (ready4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(posedge clk);
    #1;
    opA   = a;
    opB   = b;
    cinIn = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] expSum, input logic expCout, input logic expOvf);
    int n;
    applyStimulus(a, b, ci);
    checkOutput({tag, ".rdyBusy"}, 32'({ready, busy}), 32'd1);
    waitDone(n);
    checkOutput({tag, ".lat"}, 32'(n), 32'd8);
    checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
`else
    if (expOvf === 1'bx) $display("[TB] note: unexpected X in expected ovf for %s", tag);
`endif
    @(posedge clk);
    #1;
    checkOutput({tag, ".ready"}, 32'({ready, busy, done}), 32'b100);
  endtask

  initial begin
    int n;
    testCount = 0;
    failCount = 0;
    rst    = 1'b1;
    start  = 1'b0;
    opA    = '0;
    opB    = '0;
    cinIn  = 1'b0;
    start4 = 1'b0;
    opA4   = '0;
    opB4   = '0;
    cinIn4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ctrl", 32'({ready, busy, done}), 32'b100);
    checkOutput("rst.sum", 32'(sum), 32'd0);
    checkOutput("rst.cout", 32'(cout), 32'd0);
    rst = 1'b0;

    runOp("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    runOp("wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    runOp("posOv", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    runOp("negOv", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    runOp("noOv",  8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    runOp("mixed", 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);

    // start pulses during ADD and DONE must be ignored
    applyStimulus(8'h11, 8'h22, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    opA   = 8'hFF;
    opB   = 8'hFF;
    cinIn = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(n);
    checkOutput("ign.lat", 32'(n), 32'd5);
    checkOutput("ign.sum", 32'(sum), 32'h33);
    checkOutput("ign.cout", 32'(cout), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ign.ready", 32'({ready, busy}), 32'b10);
    watchNoDone("ign.noDone", 12);
    checkOutput("ign.hold", 32'({cout, sum}), 32'h033);

    // reset in the middle of ADD discards the operation
    applyStimulus(8'h55, 8'h66, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid.busy", 32'({ready, busy}), 32'b01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid.ctrl", 32'({ready, busy, done}), 32'b100);
    checkOutput("mid.sum", 32'(sum), 32'd0);
    checkOutput("mid.cout", 32'(cout), 32'd0);
    watchNoDone("mid.noDone", 12);
    runOp("after", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // exhaustive WIDTH=4 against a+b+cin
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [3:0] a4;
          logic [3:0] b4;
          logic [4:0] s5;
          a4 = 4'(a);
          b4 = 4'(b);
          s5 = 5'(a + b + c);
          @(posedge clk);
          #1;
          opA4   = a4;
          opB4   = b4;
          cinIn4 = 1'(c);
          start4 = 1'b1;
          @(posedge clk);
          #1;
          start4 = 1'b0;
          n = 0;
          while (!done4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
          end
          checkOutput("exh4.lat", 32'(n), 32'd4);
          checkOutput("exh4.sum", 32'({cout4, sum4}), 32'(s5));
`ifdef SERIAL_ADDER_OVF_EN
          checkOutput("exh4.ovf", 32'(ovf4), 32'((a4[3] == b4[3]) && (s5[3] != a4[3])));
`endif
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
